// File: rtl/round_robin_arbiter_pkg.sv
// round_robin_arbiter_pkg: shared state encoding and constants for the arbiter
package round_robin_arbiter_pkg;
  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;
  localparam int NUM_REQ = 4;
  localparam logic [1:0] RESET_LAST = 2'd3;
endpackage

// File: rtl/round_robin_arbiter_if.sv
// round_robin_arbiter_if: request/grant bundle between requesters and the arbiter
interface round_robin_arbiter_if;
  import round_robin_arbiter_pkg::*;
  logic [NUM_REQ-1:0] req;
  logic done;
  logic [NUM_REQ-1:0] gnt;
  logic [1:0] gnt_id;
  logic gnt_valid;
  logic timeout;
  modport master (output req, done, input gnt, gnt_id, gnt_valid, timeout);
  modport slave (input req, done, output gnt, gnt_id, gnt_valid, timeout);
endinterface

// File: rtl/round_robin_arbiter_rr_pick.sv
// rr_pick: rotating-priority winner search starting just after the last grantee
module rr_pick
  import round_robin_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [1:0]         last,
  output logic [1:0]         pick,
  output logic               any
);
  logic [1:0] s;
  logic [1:0] idx;
  logic [2*NUM_REQ-1:0] dbl;
  logic [NUM_REQ-1:0] rot;
  always_comb begin
    s = last + 2'd1;
    dbl = {req, req} >> s;
    rot = dbl[NUM_REQ-1:0];
    idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) if (rot[i]) idx = i[1:0];
    pick = idx + s;
    any = |req;
  end
endmodule

// File: rtl/round_robin_arbiter.sv
// round_robin_arbiter: two-state grant FSM with hold limit over a rotating-priority pick
module round_robin_arbiter
  import round_robin_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input logic clk,
  input logic rst,
  round_robin_arbiter_if.slave bus
);
  localparam int HW = $clog2(MAX_HOLD + 1);
  state_t state_q, state_d;
  logic [1:0] last_q, last_d, gnt_id_q, gnt_id_d, pick;
  logic [HW-1:0] hold_q, hold_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic timeout_q, timeout_d, any, at_limit, rel, grab;
  rr_pick u_pick (.req(bus.req), .last(last_q), .pick(pick), .any(any));
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q <= RESET_LAST;
      hold_q <= '0;
      gnt_q <= '0;
      gnt_id_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q <= last_d;
      hold_q <= hold_d;
      gnt_q <= gnt_d;
      gnt_id_q <= gnt_id_d;
      timeout_q <= timeout_d;
    end
  end
  always_comb begin
    at_limit = hold_q == HW'(MAX_HOLD);
    rel = bus.done | ~bus.req[gnt_id_q] | at_limit;
    state_d = state_q == IDLE ? (any ? GRANT : IDLE) : (rel ? IDLE : GRANT);
  end
  // done and a dropped request outrank the hold limit, so only a pure limit hit pulses timeout
  always_comb begin
    grab = state_q == IDLE && any;
    last_d = grab ? pick : last_q;
    gnt_id_d = grab ? pick : gnt_id_q;
    gnt_d = state_d == GRANT ? (grab ? 4'b0001 << pick : gnt_q) : '0;
    hold_d = grab ? HW'(1) : (state_q == GRANT && !rel) ? hold_q + HW'(1) : '0;
    timeout_d = state_q == GRANT && !bus.done && bus.req[gnt_id_q] && at_limit;
  end
  assign bus.gnt = gnt_q;
  assign bus.gnt_id = gnt_id_q;
  assign bus.gnt_valid = state_q == GRANT;
  assign bus.timeout = timeout_q;
endmodule

// File: tb/tb_round_robin_arbiter.sv
// tb_round_robin_arbiter: directed vectors with hand-computed grant sequences
module tb_round_robin_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [3:0] exp_seq [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [1:0] exp_id [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
  round_robin_arbiter_if bus ();
  round_robin_arbiter #(.MAX_HOLD(8)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", tag, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    bus.req = '0;
    bus.done = 1'b0;
    step();
    step();
    chk("rst_gnt", 8'(bus.gnt), 8'h0);
    chk("rst_valid", 8'(bus.gnt_valid), 8'h0);
    chk("rst_timeout", 8'(bus.timeout), 8'h0);
    chk("rst_id", 8'(bus.gnt_id), 8'h0);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("idle_gnt", 8'(bus.gnt), 8'h0);
      chk("idle_valid", 8'(bus.gnt_valid), 8'h0);
      chk("idle_timeout", 8'(bus.timeout), 8'h0);
    end
    bus.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("rr_gnt", 8'(bus.gnt), 8'(exp_seq[k]));
      chk("rr_id", 8'(bus.gnt_id), 8'(exp_id[k]));
      chk("rr_valid", 8'(bus.gnt_valid), 8'h1);
      bus.done = 1'b1;
      step();
      chk("rr_gap", 8'(bus.gnt), 8'h0);
      chk("rr_gap_valid", 8'(bus.gnt_valid), 8'h0);
      bus.done = 1'b0;
    end
    bus.req = 4'b0100;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("hold_gnt", 8'(bus.gnt), 8'h04);
      chk("hold_timeout", 8'(bus.timeout), 8'h0);
    end
    step();
    chk("to_gnt", 8'(bus.gnt), 8'h0);
    chk("to_pulse", 8'(bus.timeout), 8'h1);
    chk("to_id_kept", 8'(bus.gnt_id), 8'h2);
    step();
    chk("to_regrant", 8'(bus.gnt), 8'h04);
    chk("to_pulse_end", 8'(bus.timeout), 8'h0);
    bus.req = 4'b0000;
    step();
    chk("drop_rel", 8'(bus.gnt), 8'h0);
    chk("drop_no_to", 8'(bus.timeout), 8'h0);
    bus.req = 4'b0010;
    step();
    chk("own1_gnt", 8'(bus.gnt), 8'h02);
    bus.req = 4'b1001;
    step();
    chk("own1_rel", 8'(bus.gnt), 8'h0);
    step();
    chk("after1_gnt", 8'(bus.gnt), 8'h08);
    chk("after1_id", 8'(bus.gnt_id), 8'h3);
    bus.req = 4'b0000;
    step();
    chk("after1_rel", 8'(bus.gnt), 8'h0);
    bus.req = 4'b0001;
    step();
    chk("lim_gnt", 8'(bus.gnt), 8'h01);
    for (int i = 0; i < 7; i++) step();
    chk("lim_still", 8'(bus.gnt), 8'h01);
    bus.done = 1'b1;
    step();
    chk("lim_done_rel", 8'(bus.gnt), 8'h0);
    chk("lim_done_no_to", 8'(bus.timeout), 8'h0);
    bus.done = 1'b0;
    bus.req = 4'b0000;
    step();
    bus.req = 4'b0100;
    step();
    chk("pre_rst_gnt", 8'(bus.gnt), 8'h04);
    rst = 1'b1;
    step();
    chk("mid_rst_gnt", 8'(bus.gnt), 8'h0);
    chk("mid_rst_valid", 8'(bus.gnt_valid), 8'h0);
    chk("mid_rst_timeout", 8'(bus.timeout), 8'h0);
    rst = 1'b0;
    bus.req = 4'b0101;
    step();
    chk("post_rst_gnt", 8'(bus.gnt), 8'h01);
    chk("post_rst_id", 8'(bus.gnt_id), 8'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
